// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one operation in flight, result broadcast on the mul_* CDB lane.
module mul_div_unit #(
    parameter int XLEN      = 32,
    parameter int ROB_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
    input  logic [2:0]           multop,
    input  logic [ROB_IDX_W-1:0] rd_rob_idx,
    input  logic [4:0]           rd_addr,
    input  logic                 flush,
    output logic                 mul_valid,
    output logic [XLEN-1:0]      mul_data,
    output logic [ROB_IDX_W-1:0] mul_rob_idx,
    output logic [4:0]           mul_rd_addr
);

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mult_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    mult_op_t               op_in;
    mult_op_t               op_q;
    logic [5:0]             cnt;
    logic                   sign_a;
    logic                   sign_b;
    logic [XLEN-1:0]        hi;
    logic [XLEN-1:0]        lo;
    logic [XLEN-1:0]        opnd;
    logic [ROB_IDX_W-1:0]   tag_q;
    logic [4:0]             rd_q;

    logic                   accept;
    logic                   last_iter;
    logic                   sa_in;
    logic                   sb_in;
    logic [XLEN-1:0]        abs_a;
    logic [XLEN-1:0]        abs_b;
    logic                   div_zero;
    logic                   div_ovf;
    logic                   is_special;
    logic [XLEN-1:0]        special_res;

    logic [XLEN:0]          mul_sum;
    logic [2*XLEN-1:0]      mul_step;
    logic [XLEN:0]          div_shift;
    logic                   div_ok;
    logic [XLEN-1:0]        div_rem;
    logic [2*XLEN-1:0]      div_step;

    logic [2*XLEN-1:0]      prod_fix;
    logic [XLEN-1:0]        quo_fix;
    logic [XLEN-1:0]        rem_fix;
    logic [XLEN-1:0]        fix_res;

    assign op_in     = mult_op_t'(multop);
    assign accept    = issue_valid && issue_ready && !flush;
    assign last_iter = (cnt == 6'd31);

    // Operand signedness, magnitudes and the results that bypass the iterative datapath
    always_comb begin
        sa_in = 1'b0;
        sb_in = 1'b0;
        case (op_in)
            OP_MULH, OP_DIV, OP_REM: begin
                sa_in = rs1_data[XLEN-1];
                sb_in = rs2_data[XLEN-1];
            end
            OP_MULHSU: sa_in = rs1_data[XLEN-1];
            default: ;
        endcase
        abs_a    = sa_in ? -rs1_data : rs1_data;
        abs_b    = sb_in ? -rs2_data : rs2_data;
        div_zero = multop[2] && (rs2_data == '0);
        div_ovf  = multop[2] && !multop[0]
                   && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
        is_special  = div_zero || div_ovf;
        special_res = '0;
        if (div_zero)
            special_res = multop[1] ? rs1_data : '1;
        else if (div_ovf)
            special_res = multop[1] ? '0 : rs1_data;
    end

    // One iteration of each datapath; {hi,lo} is the product, or remainder/quotient
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        mul_step  = {mul_sum, lo[XLEN-1:1]};
        div_shift = {hi, lo[XLEN-1]};
        div_ok    = (div_shift >= {1'b0, opnd});
        div_rem   = XLEN'(div_shift - {1'b0, opnd});
        div_step  = div_ok ? {div_rem, lo[XLEN-2:0], 1'b1}
                           : {div_shift[XLEN-1:0], lo[XLEN-2:0], 1'b0};
    end

    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -{hi, lo} : {hi, lo};
        quo_fix  = (sign_a ^ sign_b) ? -lo : lo;
        rem_fix  = sign_a ? -hi : hi;
        case (op_q)
            OP_MUL:                      fix_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             fix_res = quo_fix;
            default:                     fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = is_special ? DONE : BUSY;
            BUSY: if (last_iter) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    always_comb begin
        issue_ready = (state == IDLE);
        mul_valid   = (state == DONE) && !flush;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q   <= OP_MUL;
            cnt    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            tag_q  <= '0;
            rd_q   <= '0;
        end else if (accept) begin
            op_q   <= op_in;
            cnt    <= '0;
            sign_a <= sa_in;
            sign_b <= sb_in;
            tag_q  <= rd_rob_idx;
            rd_q   <= rd_addr;
            hi     <= '0;
            // Multiply iterates over the multiplier in lo; divide shifts the dividend out of lo
            if (multop[2]) begin
                lo   <= abs_a;
                opnd <= abs_b;
            end else begin
                lo   <= abs_b;
                opnd <= abs_a;
            end
        end else if (state == BUSY) begin
            cnt      <= cnt + 6'd1;
            {hi, lo} <= op_q[2] ? div_step : mul_step;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_data    <= '0;
            mul_rob_idx <= '0;
            mul_rd_addr <= '0;
        end else if (accept && is_special) begin
            mul_data    <= special_res;
            mul_rob_idx <= rd_rob_idx;
            mul_rd_addr <= rd_addr;
        end else if (state == FIX && !flush) begin
            mul_data    <= fix_res;
            mul_rob_idx <= tag_q;
            mul_rd_addr <= rd_q;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: arithmetic reference model with cycle-level timing expectations,
// checked every cycle, plus directed literal results and random operations.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [2:0]  multop = '0;
    logic [4:0]  rd_rob_idx = '0;
    logic [4:0]  rd_addr = '0;
    logic        flush = 1'b0;
    logic        mul_valid;
    logic [31:0] mul_data;
    logic [4:0]  mul_rob_idx;
    logic [4:0]  mul_rd_addr;

    mul_div_unit #(.XLEN(32), .ROB_IDX_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .multop(multop), .rd_rob_idx(rd_rob_idx),
        .rd_addr(rd_addr), .flush(flush), .mul_valid(mul_valid), .mul_data(mul_data),
        .mul_rob_idx(mul_rob_idx), .mul_rd_addr(mul_rd_addr)
    );

    always #5 clk = ~clk;

    int tot = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        return op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    // Model: at most one op in flight; it is done after its valid cycle, flush or reset
    bit          armed = 0;
    bit          m_pending = 0;
    bit          m_zero = 0;
    int          m_acc = 0;
    int          m_vcyc = 0;
    logic [31:0] m_data;
    logic [4:0]  m_tag, m_rd;
    logic [31:0] last_data = '0;
    int          last_lat = -1;
    logic [31:0] res_q[$];

    always @(negedge clk) begin
        bit exp_v;
        if (armed) begin
            exp_v = m_pending && (cyc == m_vcyc) && !flush;
            chk("issue_ready", {31'b0, issue_ready}, {31'b0, !m_pending});
            chk("mul_valid", {31'b0, mul_valid}, {31'b0, exp_v});
            if (exp_v) begin
                chk("mul_data", mul_data, m_data);
                chk("mul_rob_idx", {27'b0, mul_rob_idx}, {27'b0, m_tag});
                chk("mul_rd_addr", {27'b0, mul_rd_addr}, {27'b0, m_rd});
                last_data = mul_data;
                last_lat  = cyc - m_acc;
                res_q.push_back(mul_data);
            end
            if (m_zero) begin
                chk("reset_data", mul_data, 32'h0);
                chk("reset_tag", {27'b0, mul_rob_idx}, 32'h0);
                chk("reset_rd", {27'b0, mul_rd_addr}, 32'h0);
            end
        end
        if (!rst_n) begin
            m_pending = 0;
            m_zero    = 1;
            armed     = 1;
        end else if (flush) begin
            m_pending = 0;
        end else if (m_pending) begin
            if (cyc == m_vcyc) m_pending = 0;
        end else if (issue_valid) begin
            m_pending = 1;
            m_zero    = 0;
            m_acc     = cyc + 1;
            m_vcyc    = is_special(multop, rs1_data, rs2_data) ? cyc + 1 : cyc + 34;
            m_data    = ref_res(multop, rs1_data, rs2_data);
            m_tag     = rd_rob_idx;
            m_rd      = rd_addr;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [4:0] rd);
        bit acc;
        issue_valid = 1'b1;
        multop      = op;
        rs1_data    = a;
        rs2_data    = b;
        rd_rob_idx  = tag;
        rd_addr     = rd;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = issue_ready && !flush && rst_n;
            @(posedge clk);
            #1;
            if (acc) begin
                issue_valid = 1'b0;
                return;
            end
        end
        issue_valid = 1'b0;
        chk("issue_timeout", 32'h1, 32'h0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (!m_pending) return;
        end
        chk("done_timeout", 32'h1, 32'h0);
    endtask

    task automatic run(input string nm, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        issue(op, a, b, 5'd3, 5'd7);
        wait_done();
        chk(nm, last_data, exp);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return $urandom_range(0, 15);
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd9, 5'd5);
        wait_done();
        chk("mul_7x-3", last_data, 32'hFFFFFFEB);
        chk("mul_latency", last_lat, 32'd33);

        run("mulh_min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000);
        run("mulhu_max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run("mulhsu_m1", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run("div_-7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        run("rem_-7_2", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        run("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14);
        run("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2);
        run("div_by_0", 3'd4, 32'd5, 32'd0, 32'hFFFFFFFF);
        chk("special_latency", last_lat, 32'd0);
        run("rem_by_0", 3'd6, 32'd5, 32'd0, 32'd5);
        run("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0);

        // Flush in the 10th BUSY cycle
        issue(3'd0, 32'd11, 32'd13, 5'd21, 5'd1);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("ready_after_flush", {31'b0, issue_ready}, 32'h1);
        @(posedge clk);
        #1;
        run("mulhu_3x5", 3'd3, 32'd3, 32'd5, 32'h0);

        // Flush during the DONE cycle
        issue(3'd5, 32'd1000, 32'd3, 5'd4, 5'd2);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (cyc == m_vcyc) break;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_done", {31'b0, mul_valid}, 32'h0);
        @(posedge clk);
        #1 flush = 1'b0;
        wait_done();

        // Issue coinciding with flush is dropped, then accepted afterwards
        issue_valid = 1'b1;
        multop = 3'd5; rs1_data = 32'd50; rs2_data = 32'd6; rd_rob_idx = 5'd8; rd_addr = 5'd8;
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        issue(3'd5, 32'd50, 32'd6, 5'd8, 5'd8);
        wait_done();
        chk("divu_after_drop", last_data, 32'd8);

        // issue_valid held high across two operations
        res_q.delete();
        issue(3'd1, 32'hFFFFFFFE, 32'd3, 5'd10, 5'd11);
        issue(3'd7, 32'd77, 32'd10, 5'd12, 5'd13);
        wait_done();
        chk("b2b_count", res_q.size(), 32'd2);
        if (res_q.size() == 2) begin
            chk("b2b_first", res_q[0], 32'hFFFFFFFF);
            chk("b2b_second", res_q[1], 32'd7);
        end

        // Reset in the middle of BUSY
        issue(3'd4, 32'd12345, 32'd17, 5'd30, 5'd31);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_data", mul_data, 32'h0);
        chk("rst_mid_valid", {31'b0, mul_valid}, 32'h0);
        repeat (40) @(posedge clk);
        #1;

        for (int k = 0; k < 150; k++) begin
            logic [4:0] tg;
            tg = k[4:0];
            issue(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(), tg, 5'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 35)) @(posedge clk);
                #1 flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
            end
            wait_done();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
